// File: rtl/uart_baud_gen_if.sv
// Control/status bundle between a UART controller and the baud tick generator.
// The controller drives enable, divisor and sync; the generator returns the strobes.
`timescale 1ns/1ps
interface uart_baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) ();
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              cfg_load;
  logic              sync;
  logic              os_tick;
  logic              bit_tick;
  logic              baud_clk;
  logic              cfg_pending;

  modport master (
    output en, div_int, div_frac, cfg_load, sync,
    input  os_tick, bit_tick, baud_clk, cfg_pending
  );

  modport slave (
    input  en, div_int, div_frac, cfg_load, sync,
    output os_tick, bit_tick, baud_clk, cfg_pending
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Runtime-programmable UART baud tick generator: integer + fractional divider
// producing oversample strobes, per-bit strobes and a baud-rate square wave.
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int RST_DIV    = 54,
  parameter int RST_FRAC   = 4
) (
  input logic             clk,
  input logic             rst_n,
  uart_baud_gen_if.slave  bus
);
  localparam int CNT_W = DIV_W + 1;
  localparam int PH_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  logic [CNT_W-1:0]  os_cnt_q,   os_cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic [PH_W-1:0]   os_phase_q, os_phase_d;
  logic [DIV_W-1:0]  div_act_q,  div_act_d;
  logic [FRAC_W-1:0] frac_act_q, frac_act_d;
  logic [DIV_W-1:0]  div_shd_q,  div_shd_d;
  logic [FRAC_W-1:0] frac_shd_q, frac_shd_d;
  logic              pending_q,  pending_d;
  logic              os_tick_q,  os_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              baud_q,     baud_d;

  logic [FRAC_W:0]   frac_sum;
  logic [CNT_W-1:0]  period_len;
  logic [CNT_W-1:0]  cnt_inc;
  logic              tick_now;
  logic [PH_W-1:0]   phase_inc;

  // The carry is fixed for the whole period since neither frac_acc nor the
  // active fraction changes except on the tick that ends the period.
  assign frac_sum   = {1'b0, frac_acc_q} + {1'b0, frac_act_q};
  assign period_len = {1'b0, div_act_q} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]};
  assign cnt_inc    = os_cnt_q + CNT_W'(1);
  // >= guards against a divisor shrinking below the current count while idle.
  assign tick_now   = bus.en && (cnt_inc >= period_len);
  assign phase_inc  = (os_phase_q == PH_LAST) ? '0 : os_phase_q + PH_W'(1);

  always_comb begin
    os_cnt_d   = os_cnt_q;
    frac_acc_d = frac_acc_q;
    os_phase_d = os_phase_q;
    div_act_d  = div_act_q;
    frac_act_d = frac_act_q;
    div_shd_d  = div_shd_q;
    frac_shd_d = frac_shd_q;
    pending_d  = pending_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    baud_d     = baud_q;

    if (bus.cfg_load) begin
      div_shd_d  = bus.div_int;
      frac_shd_d = bus.div_frac;
      pending_d  = 1'b1;
    end

    if (bus.sync) begin
      os_cnt_d   = '0;
      frac_acc_d = '0;
      os_phase_d = PH_HALF;
      baud_d     = 1'b1;
      if (bus.cfg_load) begin
        div_act_d  = clamp_div(bus.div_int);
        frac_act_d = bus.div_frac;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        div_act_d  = clamp_div(div_shd_q);
        frac_act_d = frac_shd_q;
        pending_d  = 1'b0;
      end
    end else if (bus.en) begin
      if (tick_now) begin
        os_cnt_d   = '0;
        frac_acc_d = frac_sum[FRAC_W-1:0];
        os_phase_d = phase_inc;
        os_tick_d  = 1'b1;
        bit_tick_d = (os_phase_q == PH_LAST);
        baud_d     = (phase_inc >= PH_HALF);
        // A load landing on the tick edge stays pending for the next tick.
        if (pending_q && !bus.cfg_load) begin
          div_act_d  = clamp_div(div_shd_q);
          frac_act_d = frac_shd_q;
          pending_d  = 1'b0;
        end
      end else begin
        os_cnt_d = cnt_inc;
      end
    end else if (pending_q && !bus.cfg_load) begin
      div_act_d  = clamp_div(div_shd_q);
      frac_act_d = frac_shd_q;
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt_q   <= '0;
      frac_acc_q <= '0;
      os_phase_q <= '0;
      div_act_q  <= clamp_div(DIV_W'(RST_DIV));
      frac_act_q <= FRAC_W'(RST_FRAC);
      div_shd_q  <= '0;
      frac_shd_q <= '0;
      pending_q  <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      baud_q     <= 1'b0;
    end else begin
      os_cnt_q   <= os_cnt_d;
      frac_acc_q <= frac_acc_d;
      os_phase_q <= os_phase_d;
      div_act_q  <= div_act_d;
      frac_act_q <= frac_act_d;
      div_shd_q  <= div_shd_d;
      frac_shd_q <= frac_shd_d;
      pending_q  <= pending_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      baud_q     <= baud_d;
    end
  end

  assign bus.os_tick     = os_tick_q;
  assign bus.bit_tick    = bit_tick_q;
  assign bus.baud_clk    = baud_q;
  assign bus.cfg_pending = pending_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: divisor table, hand-written corner
// sequences and a randomized run against an arithmetic tick-time model.
`timescale 1ns/1ps
module tb_uart_baud_gen;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

  uart_baud_gen #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OVS), .RST_DIV(54), .RST_FRAC(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int di;
    int df;
    int os_first;
    int first_bit;
    int bit_per;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // which: 0 = os_tick, 1 = bit_tick, 2 = baud_clk rising
  task automatic wait_ev(input int which, input string name, input int limit, output int n);
    logic prev, hit;
    prev = bus.baud_clk;
    hit  = 1'b0;
    n    = 0;
    while (!hit && n < limit) begin
      step();
      n++;
      case (which)
        0:       hit = bus.os_tick;
        1:       hit = bus.bit_tick;
        default: hit = bus.baud_clk & ~prev;
      endcase
      prev = bus.baud_clk;
    end
    check1({name, "_seen"}, hit, 1'b1);
  endtask

  task automatic expect_ev(input int which, input string name, input int exp);
    int n;
    wait_ev(which, name, exp * 2 + 20, n);
    checkn(name, n, exp);
  endtask

  task automatic reset_idle();
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.cfg_load = 1'b0;
    bus.sync     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic load_idle(input int di, input int df);
    bus.div_int  = DIV_W'(di);
    bus.div_frac = FRAC_W'(df);
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    check1("idle_load_pending", bus.cfg_pending, 1'b1);
    step();
    check1("idle_load_applied", bus.cfg_pending, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    int n, m;
    bus.en       = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.cfg_load = 1'b0;
    bus.sync     = 1'b0;

    vecs[0] = '{54, 4,  54, 868, 868};
    vecs[1] = '{4,  0,  4,  64,  64};
    vecs[2] = '{0,  0,  2,  32,  32};
    vecs[3] = '{1,  0,  2,  32,  32};
    vecs[4] = '{2,  8,  2,  40,  40};
    vecs[5] = '{10, 15, 10, 175, 175};
    vecs[6] = '{3,  1,  3,  49,  49};
    vecs[7] = '{0,  15, 2,  47,  47};

    // Reset state and default 54.25 divider.
    rst_n = 1'b0;
    step();
    step();
    check1("rst_os_tick", bus.os_tick, 1'b0);
    check1("rst_bit_tick", bus.bit_tick, 1'b0);
    check1("rst_baud_clk", bus.baud_clk, 1'b0);
    check1("rst_cfg_pending", bus.cfg_pending, 1'b0);
    bus.en = 1'b1;
    rst_n  = 1'b1;
    expect_ev(0, "default_os_first", 54);
    for (int p = 2; p <= 8; p++) expect_ev(0, "default_os_period", (p % 4 == 0) ? 55 : 54);
    $display("default os pattern checked");

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_ev(1, "default_bit_first", 868);
    for (int b = 0; b < 20; b++) expect_ev(1, "default_bit_per", 868);
    check1("baud_low_at_bit", bus.baud_clk, 1'b0);
    expect_ev(2, "baud_first_rise", 434);
    expect_ev(2, "baud_period", 868);
    $display("default bit and baud timing checked");

    // Mid-period reprogramming to 4.0.
    wait_ev(0, "align_os", 60, n);
    repeat (20) step();
    bus.div_int  = 16'd4;
    bus.div_frac = 4'd0;
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    m = 21;
    check1("cfg_pending_set", bus.cfg_pending, 1'b1);
    while (m < 200) begin
      step();
      m++;
      if (bus.os_tick === 1'b1) break;
      check1("cfg_pending_hold", bus.cfg_pending, 1'b1);
    end
    check1("cfg_pending_clear", bus.cfg_pending, 1'b0);
    check1("straddle_not_short", (m >= 54), 1'b1);
    for (int i = 0; i < 8; i++) expect_ev(0, "new_os_period", 4);
    wait_ev(1, "align_bit", 200, n);
    expect_ev(1, "new_bit_period", 64);
    expect_ev(1, "new_bit_period", 64);
    $display("reprogram to 4.0 checked");

    // Sync at an arbitrary phase.
    wait_ev(0, "align_os2", 10, n);
    step();
    step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    check1("sync_no_os_tick", bus.os_tick, 1'b0);
    check1("sync_no_bit_tick", bus.bit_tick, 1'b0);
    check1("sync_baud_high", bus.baud_clk, 1'b1);
    expect_ev(1, "sync_first_bit", 32);
    expect_ev(1, "sync_bit_period", 64);
    $display("sync checked");

    // Enable stall of 100 cycles, 23 enabled cycles into a bit.
    repeat (23) step();
    check1("pre_stall_baud", bus.baud_clk, 1'b0);
    bus.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      check1("stall_no_os", bus.os_tick, 1'b0);
      check1("stall_no_bit", bus.bit_tick, 1'b0);
      check1("stall_baud_hold", bus.baud_clk, 1'b0);
    end
    bus.en = 1'b1;
    expect_ev(1, "stall_remaining", 64 - 23);
    expect_ev(1, "post_stall_period", 64);
    $display("enable stall checked");

    // Reset mid-bit with a pending config that must be discarded.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (500) step();
    bus.div_int  = 16'd4;
    bus.div_frac = 4'd0;
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    check1("pre_rst_pending", bus.cfg_pending, 1'b1);
    check1("pre_rst_baud", bus.baud_clk, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("async_rst_os", bus.os_tick, 1'b0);
    check1("async_rst_bit", bus.bit_tick, 1'b0);
    check1("async_rst_baud", bus.baud_clk, 1'b0);
    check1("async_rst_pending", bus.cfg_pending, 1'b0);
    step();
    rst_n = 1'b1;
    expect_ev(0, "post_rst_os", 54);
    expect_ev(0, "post_rst_os", 54);
    expect_ev(0, "post_rst_os", 54);
    expect_ev(0, "post_rst_os", 55);
    expect_ev(1, "post_rst_bit", 868 - 217);
    $display("mid-bit reset checked");

    // Divisor table.
    foreach (vecs[i]) begin
      reset_idle();
      load_idle(vecs[i].di, vecs[i].df);
      bus.en = 1'b1;
      expect_ev(0, "vec_os_first", vecs[i].os_first);
      expect_ev(1, "vec_bit_first", vecs[i].first_bit - vecs[i].os_first);
      expect_ev(1, "vec_bit_period", vecs[i].bit_per);
      $display("vector %0d div=%0d frac=%0d checked", i, vecs[i].di, vecs[i].df);
    end

    // Randomized divisor and enable pattern against tick-time arithmetic:
    // the k-th os_tick lands on enabled cycle k*D + floor(k*F / 2^FRAC_W).
    for (int t = 0; t < 8; t++) begin
      int d, f, de, en_cnt, k, t_next;
      logic en_v, exp_os, exp_bit, exp_baud;
      d  = int'($urandom_range(0, 12));
      f  = int'($urandom_range(0, 15));
      de = (d < 2) ? 2 : d;
      reset_idle();
      load_idle(d, f);
      en_cnt = 0;
      k      = 0;
      for (int c = 0; c < 400; c++) begin
        en_v   = ($urandom_range(0, 3) != 0);
        bus.en = en_v;
        step();
        exp_os  = 1'b0;
        exp_bit = 1'b0;
        if (en_v) begin
          en_cnt++;
          t_next = de * (k + 1) + (((k + 1) * f) >> FRAC_W);
          if (en_cnt == t_next) begin
            k++;
            exp_os  = 1'b1;
            exp_bit = (k % OVS == 0);
          end
        end
        exp_baud = ((k % OVS) >= OVS / 2);
        check1("rand_os_tick", bus.os_tick, exp_os);
        check1("rand_bit_tick", bus.bit_tick, exp_bit);
        check1("rand_baud_clk", bus.baud_clk, exp_baud);
      end
      $display("random trial %0d div=%0d frac=%0d ticks=%0d", t, d, f, k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Parametrised, runtime-programmable UART baud tick generator. Successor to the fixed divide-by-868 baud clock.
- Produces, from the single 100 MHz system clock:
  - an oversample strobe (os_tick),
  - a per-bit strobe (bit_tick),
  - a square-wave baud_clk.
- Uses an integer + fractional divider, so standard baud rates are hit without cumulative drift.
- Feeds both the UART TX serializer (bit_tick) and the RX sampler (os_tick, plus sync for start-bit alignment).

Parameters:
- DIV_W, 16, width of the integer divisor.
- FRAC_W, 4, width of the fractional divisor; fraction = div_frac / 2^FRAC_W.
- OVERSAMPLE, 16, os_ticks per bit. Must be an even power of two, >= 2.
- RST_DIV, 54, integer divisor loaded into the active register at reset.
- RST_FRAC, 4, fractional divisor loaded at reset. 54 + 4/16 = 54.25 gives 115200 baud x16 at 100 MHz.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, generator enable. When low, all counters freeze.
- div_int, input, DIV_W, requested integer divisor (clocks per os_tick).
- div_frac, input, FRAC_W, requested fractional divisor.
- cfg_load, input, 1, one-cycle pulse that captures div_int/div_frac into the shadow register.
- sync, input, 1, one-cycle pulse that re-phases the generator to mid-bit (RX start-bit detect).
- os_tick, output, 1, one-cycle pulse once per oversample period.
- bit_tick, output, 1, one-cycle pulse once per bit period; always coincident with an os_tick.
- baud_clk, output, 1, square wave at the baud rate: low during the first half of a bit, high during the second half.
- cfg_pending, output, 1, high while a shadow config awaits transfer to the active registers.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
  - Reset state: os_tick=0, bit_tick=0, baud_clk=0, cfg_pending=0.
  - Reset state: os_cnt=0, frac_acc=0, os_phase=0; active divisor = RST_DIV/RST_FRAC.
- All outputs are registered. No combinational paths from inputs to outputs.
- Divisor clamp: an effective integer divisor below 2 (captured value 0 or 1) is clamped to 2.
- Fractional divider:
  - Each oversample period lasts D + c clocks, where D is the active integer divisor.
  - c is the carry out of the FRAC_W-bit addition frac_acc + active_frac, evaluated at the start of the period.
  - frac_acc takes the truncated sum at each os_tick.
  - Example, 54.25: periods run 54, 54, 54, 55 and repeat. Four periods total 217 clocks.
- os_tick:
  - Asserted for exactly one cycle at the end of each period.
  - With en held high from reset release, the first os_tick occurs in the Dth enabled cycle, i.e. first period c=0.
- os_phase and bit_tick:
  - os_phase counts 0..OVERSAMPLE-1, advancing on each os_tick and wrapping to 0.
  - bit_tick asserts together with the os_tick on which os_phase wraps from OVERSAMPLE-1 to 0.
- baud_clk: registered value of (os_phase >= OVERSAMPLE/2), updated on os_tick.
- en low:
  - os_cnt, frac_acc and os_phase hold.
  - os_tick and bit_tick are forced to 0 from the next cycle.
  - baud_clk holds.
  - Counting resumes exactly where it stopped.
- cfg_load:
  - Captures div_int/div_frac into the shadow register and sets cfg_pending.
  - The shadow is transferred to the active registers on the cycle the next os_tick is generated, so the new period starts cleanly.
  - The transfer clears cfg_pending. frac_acc and os_phase are not reset.
  - If en=0, the transfer happens on the next clock and cfg_pending is high for one cycle.
  - A second cfg_load while pending overwrites the shadow; only the last value is applied.
- sync:
  - On the next clock: os_cnt=0, frac_acc=0, os_phase=OVERSAMPLE/2, baud_clk=1; no tick in that cycle.
  - Result: the first bit_tick comes OVERSAMPLE/2 os periods later, i.e. mid-bit.
  - sync is honoured even when en=0.
- sync and cfg_load in the same cycle: the pending config is applied immediately, then sync applies using the new divisor; cfg_pending=0.
- sync coincident with a would-be os_tick: sync wins and the tick is suppressed.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), including any discarded pending config.

Test Plan:
- Reset, then en=1, default config. Required:
  - os_tick intervals repeat 54, 54, 54, 55.
  - bit_tick spacing exactly 868 clocks over 20 bits.
  - baud_clk period 868, 0 after reset.
- cfg_load div_int=4, div_frac=0 mid-period. Required:
  - cfg_pending=1 until the next os_tick.
  - Thereafter os_tick every 4 clocks and bit_tick every 64 clocks.
  - No os period shorter than the old or new divisor.
- div_int=0 and div_int=1 loaded. Required: os_tick every 2 clocks; bit_tick every 32.
- sync pulse at an arbitrary phase (div 4.0). Required:
  - No tick on the next cycle; baud_clk=1.
  - First bit_tick exactly 32 clocks after the sync-effective cycle, then every 64.
- en dropped for 100 cycles mid-bit. Required:
  - No ticks while low.
  - After en returns, the remaining interval to the next bit_tick equals the remaining pre-stall interval.
- rst_n pulsed low mid-bit with a cfg_load pending. Required:
  - All outputs 0 immediately.
  - After release, timing matches the default 54.25 divisor.
